indexed_lsh_extract: RTL and testbench

// - Register-backed sorted-row buffer: the removal counterpart of the indexed right-shift insert path.
// - Deletes the entry at a given index, returns it, and compacts entries above it one slot toward index 0.
// - Also drains the row in order over a valid/ready stream.
// - Sits after the insert stage in the SpMM row-merge path; it is loaded with the packed row that stage produces.

---
 rtl/indexed_lsh_extract.sv | 163 ++++++++++++++++
 tb/tb_indexed_lsh_extract.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/indexed_lsh_extract.sv
// indexed_lsh_extract: register-backed sorted-row buffer.
// It removes the entry at an index, returns that entry, and moves the entries
// above it one slot toward index 0. It can also stream the row out in order.
// The row is loaded in parallel from the insert stage. Entry 0 sits in the MSBs
// of load_arr and arr_out.
// Build option: ZERO_FILL_EN. When it is defined, slot N-1 is written to 0 on
// every compaction. When it is not defined, slot N-1 keeps its old (stale)
// value, so consumers must qualify the row with count.
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high. Ready never depends on the valid of the same channel. load_ready
// is high whenever the block is IDLE. del_ready is high in IDLE while
// load_valid is low. drain_start is taken in IDLE only when no load and no
// delete is requested. A request that loses arbitration is not accepted and
// leaves no trace. out_valid stays high with out_data held until out_ready
// is seen.
module indexed_lsh_extract #(
    parameter int N_ENTRIES = 16,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_valid,
    input  logic [N_ENTRIES*DATA_W-1:0] load_arr,
    input  logic [CNT_W-1:0]            load_count,
    output logic                        load_ready,
    input  logic                        del_valid,
    input  logic [IDX_W-1:0]            del_idx,
    output logic                        del_ready,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    input  logic                        drain_start,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        drain_done,
    output logic [N_ENTRIES*DATA_W-1:0] arr_out,
    output logic [CNT_W-1:0]            count,
    output logic                        busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_W-1:0]       arr_q [N_ENTRIES];
    logic [CNT_W-1:0]        count_q;

    logic                    idle;
    logic                    load_fire;
    logic                    del_fire;
    logic                    del_ok;
    logic                    start_fire;
    logic                    beat_fire;
    logic                    shift_en;
    logic [IDX_W-1:0]        shift_idx;
    logic [CNT_W-1:0]        load_cnt_clamped;

    // Handshake decode and arbitration. Load wins over delete, and delete wins over drain start.
    always_comb begin
        idle             = (state_q == S_IDLE);
        load_ready       = idle;
        del_ready        = idle && !load_valid;
        load_fire        = load_valid && idle;
        del_fire         = del_valid && del_ready;
        del_ok           = (CNT_W'(del_idx) < count_q);
        start_fire       = drain_start && idle && !load_valid && !del_valid;
        beat_fire        = (state_q == S_DRAIN) && out_ready;
        shift_en         = (del_fire && del_ok) || beat_fire;
        shift_idx        = beat_fire ? '0 : del_idx;
        load_cnt_clamped = (load_count > CNT_W'(N_ENTRIES)) ? CNT_W'(N_ENTRIES) : load_count;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an empty row never enters DRAIN, and the last beat returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_fire && (count_q != '0)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (beat_fire && (count_q == CNT_W'(1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Row storage: parallel load, or remove one slot and shift the upper entries down by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                arr_q[i] <= '0;
            end
            count_q <= '0;
        end else if (load_fire) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                arr_q[i] <= load_arr[(N_ENTRIES-1-i)*DATA_W +: DATA_W];
            end
            count_q <= load_cnt_clamped;
        end else if (shift_en) begin
            for (int i = 0; i < N_ENTRIES - 1; i++) begin
                if (i >= int'(shift_idx)) begin
                    arr_q[i] <= arr_q[i+1];
                end
            end
`ifdef ZERO_FILL_EN
            arr_q[N_ENTRIES-1] <= '0;
`else
            arr_q[N_ENTRIES-1] <= arr_q[N_ENTRIES-1];
`endif
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Delete response and drain completion. Each is a one-cycle pulse after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            rsp_valid  <= del_fire;
            rsp_err    <= del_fire && !del_ok;
            rsp_data   <= (del_fire && del_ok) ? arr_q[del_idx] : '0;
            drain_done <= (start_fire && (count_q == '0)) ||
                          (beat_fire && (count_q == CNT_W'(1)));
        end
    end

    // Drain beat and status outputs. Entry 0 always forms the current beat.
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DRAIN);
        out_data  = arr_q[0];
        out_last  = (state_q == S_DRAIN) && (count_q == CNT_W'(1));
        count     = count_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            arr_out[(N_ENTRIES-1-i)*DATA_W +: DATA_W] = arr_q[i];
        end
    end

endmodule

// File: tb/tb_indexed_lsh_extract.sv
// Bench for indexed_lsh_extract. It runs a table of deletes, a set of hand
// sequences for the multi-cycle cases, and random traffic.
// The reference model keeps the row as a 16-slot queue. A delete is a queue
// delete followed by a push of the vacated tail value, which is 0 when
// ZERO_FILL_EN is defined and the old tail otherwise.
module tb_indexed_lsh_extract;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int IW = 4;
    localparam int CW = 5;
`ifdef ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              load_valid;
    logic [N*W-1:0]    load_arr;
    logic [CW-1:0]     load_count;
    logic              load_ready;
    logic              del_valid;
    logic [IW-1:0]     del_idx;
    logic              del_ready;
    logic              rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              drain_start;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic              out_ready;
    logic              drain_done;
    logic [N*W-1:0]    arr_out;
    logic [CW-1:0]     count;
    logic              busy;

    indexed_lsh_extract #(.N_ENTRIES(N), .DATA_W(W), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_arr(load_arr), .load_count(load_count),
        .load_ready(load_ready),
        .del_valid(del_valid), .del_idx(del_idx), .del_ready(del_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .drain_start(drain_start), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .drain_done(drain_done),
        .arr_out(arr_out), .count(count), .busy(busy)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 16 slots, plus the count of valid entries.
    logic [W-1:0] m_q[$];
    int           m_cnt;

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  exp_data;
        logic          exp_err;
        int            exp_cnt;
    } del_vec_t;

    del_vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_arr(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < N; i++) m_q.push_back('0);
        m_cnt = 0;
    endtask

    task automatic model_load(input logic [N*W-1:0] a, input int c);
        m_q = {};
        for (int i = 0; i < N; i++) m_q.push_back(a[(N-1-i)*W +: W]);
        m_cnt = (c > N) ? N : c;
    endtask

    task automatic model_del(input int idx);
        logic [W-1:0] tail;
        tail = m_q[N-1];
        m_q.delete(idx);
        m_q.push_back(ZF ? '0 : tail);
        m_cnt--;
    endtask

    function automatic logic [N*W-1:0] model_arr();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[(N-1-i)*W +: W] = m_q[i];
        return r;
    endfunction

    // Drivers. Inputs change on the falling edge, and outputs are sampled there.
    task automatic do_load(input logic [N*W-1:0] a, input logic [CW-1:0] c);
        @(negedge clk);
        chk("load_ready", load_ready, 1);
        load_valid = 1'b1;
        load_arr   = a;
        load_count = c;
        @(negedge clk);
        load_valid = 1'b0;
        model_load(a, int'(c));
        chk("load_count", count, m_cnt);
        chk_arr("load_arr", arr_out, model_arr());
    endtask

    task automatic do_del(input logic [IW-1:0] idx, output logic [W-1:0] d, output logic e);
        logic [W-1:0] exp_d;
        logic         exp_e;
        @(negedge clk);
        chk("del_ready", del_ready, 1);
        del_valid = 1'b1;
        del_idx   = idx;
        @(negedge clk);
        del_valid = 1'b0;
        if (int'(idx) < m_cnt) begin
            exp_d = m_q[idx];
            exp_e = 1'b0;
            model_del(int'(idx));
        end else begin
            exp_d = '0;
            exp_e = 1'b1;
        end
        d = rsp_data;
        e = rsp_err;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", rsp_err, exp_e);
        chk("del_count", count, m_cnt);
        chk_arr("del_arr", arr_out, model_arr());
    endtask

    // mode 0: random out_ready; mode 1: out_ready toggles 1,0,1,0...
    task automatic run_drain(input int mode);
        int  n;
        int  beats;
        int  cyc;
        int  done_seen;
        logic tog;
        logic r;
        n = m_cnt;
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        if (n == 0) begin
            chk("empty_drain_done", drain_done, 1);
            chk("empty_drain_busy", busy, 0);
            @(negedge clk);
            chk("empty_drain_done_fall", drain_done, 0);
            return;
        end
        beats = 0; cyc = 0; done_seen = 0; tog = 1'b1;
        while (beats < n && cyc < 200) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, m_q[0]);
            chk("out_last", out_last, (m_cnt == 1));
            chk("drain_busy", busy, 1);
            if (drain_done) done_seen++;
            r = (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            out_ready = r;
            if (r) begin
                model_del(0);
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_timeout", (cyc >= 200), 0);
        chk("drain_done", drain_done, 1);
        chk("drain_done_early", done_seen, 0);
        chk("drain_end_busy", busy, 0);
        chk("drain_end_valid", out_valid, 0);
        chk("drain_end_count", count, 0);
        chk_arr("drain_end_arr", arr_out, model_arr());
        @(negedge clk);
        chk("drain_done_fall", drain_done, 0);
    endtask

    initial begin
        logic [N*W-1:0] a;
        logic [W-1:0]   d;
        logic           e;

        rst_n = 1'b0; load_valid = 1'b0; load_arr = '0; load_count = '0;
        del_valid = 1'b0; del_idx = '0; drain_start = 1'b0; out_ready = 1'b0;
        model_reset();

        // The reset state is checked while reset is still held.
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk_arr("rst_arr", arr_out, '0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drain_done", drain_done, 0);
        rst_n = 1'b1;

        // Table of deletes on the row 10..160.
        vecs[0] = '{idx: 4'd3,  exp_data: 32'd40,  exp_err: 1'b0, exp_cnt: 15};
        vecs[1] = '{idx: 4'd15, exp_data: 32'd0,   exp_err: 1'b1, exp_cnt: 15};
        vecs[2] = '{idx: 4'd0,  exp_data: 32'd10,  exp_err: 1'b0, exp_cnt: 14};
        vecs[3] = '{idx: 4'd13, exp_data: 32'd160, exp_err: 1'b0, exp_cnt: 13};
        vecs[4] = '{idx: 4'd5,  exp_data: 32'd80,  exp_err: 1'b0, exp_cnt: 12};
        vecs[5] = '{idx: 4'd12, exp_data: 32'd0,   exp_err: 1'b1, exp_cnt: 12};
        for (int i = 0; i < N; i++) a[(N-1-i)*W +: W] = W'((i + 1) * 10);
        do_load(a, 5'd16);
        for (int v = 0; v < 6; v++) begin
            do_del(vecs[v].idx, d, e);
            chk("tbl_data", d, vecs[v].exp_data);
            chk("tbl_err", e, vecs[v].exp_err);
            chk("tbl_count", count, vecs[v].exp_cnt);
            if (v == 0) begin
                chk("slot15_after_del3", arr_out[W-1:0], ZF ? 64'd0 : 64'd160);
                chk("slot3_after_del3", arr_out[(N-1-3)*W +: W], 50);
            end
        end
        @(negedge clk);
        chk("rsp_valid_pulse", rsp_valid, 0);

        // A load count above N_ENTRIES is clamped to N_ENTRIES.
        do_load(a, 5'd20);
        chk("clamp_count", count, 16);

        // Load 7,8,9 and drain it while out_ready toggles.
        a = '0;
        a[(N-1)*W +: W] = 32'd7;
        a[(N-2)*W +: W] = 32'd8;
        a[(N-3)*W +: W] = 32'd9;
        do_load(a, 5'd3);
        run_drain(1);

        // Drain of an empty row.
        run_drain(0);

        // Load and delete in the same cycle: load wins, and no response follows.
        @(negedge clk);
        load_valid = 1'b1; load_arr = a; load_count = 5'd3;
        del_valid = 1'b1; del_idx = 4'd0;
        #1;
        chk("collide_del_ready", del_ready, 0);
        @(negedge clk);
        load_valid = 1'b0; del_valid = 1'b0;
        model_load(a, 3);
        chk("collide_rsp_valid", rsp_valid, 0);
        chk("collide_count", count, 3);
        chk_arr("collide_arr", arr_out, model_arr());

        // Reset after the first drain beat clears everything at once.
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("mid_drain_count", count, 2);
        chk("mid_drain_data", out_data, 8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_busy", busy, 0);
        chk_arr("rst_mid_arr", arr_out, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) a[(N-1-i)*W +: W] = $urandom;
            do_load(a, CW'($urandom_range(0, 18)));
            for (int k = 0; k < 4; k++) begin
                do_del(IW'($urandom_range(0, N-1)), d, e);
            end
            if ($urandom_range(0, 1) == 1) run_drain(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
